// File: rtl/timer_pkg.sv
// Shared types and widths for the MM:SS timer family (stopwatch / countdown).
package timer_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 7;
    localparam int unsigned SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a seconds value into 0..59.
    function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] s);
        return (s > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, rst_n (async, active-low), en (count enable), clr (sync
// phase reset, wins over en), tick (combinational, high on the last
// phase of an enabled cycle).
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick only fires while enabled, so a masked cycle holds the last phase.
    assign tick = en && (cnt_q == CNT_LAST);

    // Phase counter: cleared, wrapped on tick, advanced only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmss_countdown_timer.sv
// Down-counting MM:SS timer with run/pause FSM and 00:00 alarm.
// Ports: clk, rst_n (async, active-low); clear (sync user reset);
// load/load_min/load_sec (preset capture, saturating); start/stop
// (resume/pause pulses); minutes/seconds (current count); running
// (decode of RUN state); expired (1-cycle pulse on reaching 00:00);
// alarm (level, held in DONE until clear or load).
module mmss_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned MAX_MIN  = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             stop,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             expired,
    output logic             alarm
);

    state_t           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             expired_q, expired_d;
    logic             alarm_q, alarm_d;

    logic             load_ok_c;
    logic             pre_en_c;
    logic             pre_clr_c;
    logic             tick_c;
    logic             count_zero_c;
    logic [MIN_W-1:0] load_min_sat_c;
    logic [SEC_W-1:0] load_sec_sat_c;

    // Load is ignored while running; it otherwise restarts the phase.
    assign load_ok_c = load && (state_q != RUN);

    // Prescaler runs only in RUN; a stop (or clear) freezes its phase so
    // a pending tick is deferred to the first cycle after resume.
    assign pre_en_c  = (state_q == RUN) && !stop && !clear;
    assign pre_clr_c = clear || load_ok_c;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pre_en_c),
        .clr  (pre_clr_c),
        .tick (tick_c)
    );

    // Preset saturation.
    assign load_sec_sat_c = sat_sec(load_sec);
    assign load_min_sat_c = (load_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : load_min;

    assign count_zero_c = (min_q == '0) && (sec_q == '0);

    // State and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            expired_q <= expired_d;
            alarm_q   <= alarm_d;
        end
    end

    // Next-state, borrow down-counter and alarm logic.
    // Priority: clear > load > stop > start.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        expired_d = 1'b0;
        alarm_d   = alarm_q;

        if (clear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
            alarm_d = 1'b0;
        end else if (load_ok_c) begin
            state_d = IDLE;
            min_d   = load_min_sat_c;
            sec_d   = load_sec_sat_c;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop && !count_zero_c) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick_c) begin
                        // RUN is never entered at 00:00, so a borrow always
                        // has a nonzero minute to take from.
                        if (sec_q != '0) begin
                            sec_d = sec_q - SEC_W'(1);
                        end else begin
                            sec_d = SEC_W'(SEC_MAX);
                            min_d = min_q - MIN_W'(1);
                        end
                        if ((min_q == '0) && (sec_q == SEC_W'(1))) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                            alarm_d   = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign expired = expired_q;
    assign alarm   = alarm_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Bench for mmss_countdown_timer with TICK_DIV=4: a per-cycle vector table
// plus hand sequences for pause/resume phase, stop-vs-tick, alarm clear
// and asynchronous reset mid-run.
module tb_mmss_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       expired;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    mmss_countdown_timer #(
        .TICK_DIV(4),
        .MAX_MIN (99)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .stop    (stop),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .expired (expired),
        .alarm   (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       c;
        logic       l;
        logic [6:0] lm;
        logic [5:0] ls;
        logic       st;
        logic       sp;
        logic [6:0] emin;
        logic [5:0] esec;
        logic       erun;
        logic       eexp;
        logic       eal;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic l, input int lm, input int ls,
                                input logic st, input logic sp, input int emin, input int esec,
                                input logic erun, input logic eexp, input logic eal);
        vec_t v;
        v.c = c; v.l = l; v.lm = 7'(lm); v.ls = 6'(ls); v.st = st; v.sp = sp;
        v.emin = 7'(emin); v.esec = 6'(esec); v.erun = erun; v.eexp = eexp; v.eal = eal;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int em, input int es,
                           input logic er, input logic ee, input logic ea);
        chk({tag, "_min"}, int'(minutes), em);
        chk({tag, "_sec"}, int'(seconds), es);
        chk({tag, "_run"}, int'(running), int'(er));
        chk({tag, "_exp"}, int'(expired), int'(ee));
        chk({tag, "_alarm"}, int'(alarm), int'(ea));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic c, input logic l, input int lm, input int ls,
                        input logic st, input logic sp);
        clear = c; load = l; load_min = 7'(lm); load_sec = 6'(ls); start = st; stop = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0; load = 1'b0; load_min = '0; load_sec = '0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //          c  l  lm   ls  st sp  emin esec run exp al
        // load 01:00, start, first decrement 4 cycles after the start edge
        vecs.push_back(mk(0, 1,   1,  0, 0, 0,   1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   1,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   1,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   1,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   1,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0, 59, 1, 0, 0));
        // load while running is ignored
        vecs.push_back(mk(0, 1, 120, 63, 0, 0,   0, 59, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 1,   0, 59, 0, 0, 0));
        // saturating load from PAUSE
        vecs.push_back(mk(0, 1, 120, 63, 0, 0,  99, 59, 0, 0, 0));
        // clear beats load and start in the same cycle
        vecs.push_back(mk(1, 1,   7,  7, 1, 0,   0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  0, 0, 0, 0));
        // load 00:02 runs down to expiry
        vecs.push_back(mk(0, 1,   0,  2, 0, 0,   0,  2, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0,   0,  0, 0, 0,   0,  0, 0, 0, 1));
        // DONE ignores start and stop; load clears the alarm
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0, 0, 1,   0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1,   0,  3, 0, 0,   0,  3, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].l, int'(vecs[i].lm), int'(vecs[i].ls), vecs[i].st, vecs[i].sp);
            chk_all($sformatf("row%0d", i), int'(vecs[i].emin), int'(vecs[i].esec),
                    vecs[i].erun, vecs[i].eexp, vecs[i].eal);
        end

        // Pause after 2 RUN cycles, hold 20 cycles, resume: decrement 2 cycles later.
        step(1'b0, 1'b1, 0, 10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk_all("pause_enter", 0, 10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            idle_step();
            chk("pause_hold_sec", int'(seconds), 10);
        end
        chk("pause_hold_run", int'(running), 0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        chk_all("resume_0", 0, 10, 1'b1, 1'b0, 1'b0);
        idle_step();
        chk("resume_1_sec", int'(seconds), 10);
        idle_step();
        chk("resume_2_sec", int'(seconds), 9);

        // stop on the tick cycle suppresses it; tick fires on first RUN cycle after resume.
        idle_step();
        idle_step();
        idle_step();
        chk("pre_stop_sec", int'(seconds), 9);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk_all("stop_on_tick", 0, 9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        chk_all("resume_edge", 0, 9, 1'b1, 1'b0, 1'b0);
        idle_step();
        chk_all("resume_tick", 0, 8, 1'b1, 1'b0, 1'b0);

        // Expire from 00:01, then clear drops the alarm.
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk_all("clear_run", 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        idle_step();
        chk_all("exp1_before", 0, 1, 1'b1, 1'b0, 1'b0);
        idle_step();
        chk_all("exp1_hit", 0, 0, 1'b0, 1'b1, 1'b1);
        idle_step();
        chk_all("exp1_after", 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk_all("clear_done", 0, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN at 05:30 with a tick pending.
        step(1'b0, 1'b1, 5, 30, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        idle_step();
        chk_all("pre_reset", 5, 30, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("reset_hold", 0, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        chk_all("post_reset_start", 0, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
